syscall_input_unit: RTL

//  Input side of the syscall interface, complementing the display/exit handler.
//  - Buffers console bytes from the bench/host stream in a FIFO.
//  - Services read syscalls (instr_ID 26, codes 9-11).
//  - Returns the result on rd and stalls the processor until the result is ready.
//

---
 rtl/sys_pkg.sv | 42 ++++
 rtl/sys_byte_fifo.sv | 63 ++++++
 rtl/syscall_input_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys_pkg
//  Purpose  : Shared syscall codes, ASCII constants and read-FSM state type
//  Revision : 1.0 - initial release
// ============================================================================
package sys_pkg;

    localparam int unsigned SYSCALL_ID = 26;

    localparam logic [31:0] SC_PRINT_INT   = 32'd1;
    localparam logic [31:0] SC_PRINT_HEX   = 32'd2;
    localparam logic [31:0] SC_PRINT_BIN   = 32'd3;
    localparam logic [31:0] SC_PRINT_STR   = 32'd4;
    localparam logic [31:0] SC_PRINT_CHR   = 32'd5;
    localparam logic [31:0] SC_EXIT        = 32'd6;
    localparam logic [31:0] SC_EXIT_CODE   = 32'd7;
    localparam logic [31:0] SC_PRINT_UINT  = 32'd8;
    localparam logic [31:0] SC_READ_INT    = 32'd9;
    localparam logic [31:0] SC_READ_STR    = 32'd10;
    localparam logic [31:0] SC_READ_CHR    = 32'd11;

    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_INT = 3'd1,
        RD_STR = 3'd2,
        RD_CHR = 3'd3,
        DONE   = 3'd4
    } rd_state_t;

    function automatic logic is_read_code(input logic [31:0] code);
        return (code == SC_READ_INT) || (code == SC_READ_STR) || (code == SC_READ_CHR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sys_byte_fifo
//  Purpose  : First-word-fall-through byte FIFO, power-of-two depth
//  Revision : 1.0 - initial release
// ============================================================================
module sys_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/syscall_input_unit.sv
`default_nettype none
// ============================================================================
//  Module   : syscall_input_unit
//  Purpose  : Console input side of the syscall interface (read int/str/char)
//  Revision : 1.0 - initial release
// ============================================================================
module syscall_input_unit #(
    parameter int FIFO_DEPTH = 16,
    parameter int SYSCALL_ID = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_ID,
    input  logic [31:0] rs,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] rd,
    output logic        rd_valid,
    output logic        stall
);

    import sys_pkg::*;

    rd_state_t   state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rd_q, rd_d;
    logic        neg_q, neg_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        req, in_read, pop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  head;
    logic        is_digit, is_space;
    logic [31:0] digit, acc_next, str_byte;

    sys_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req      = (instr_ID == 32'(SYSCALL_ID)) && is_read_code(rs);
    assign in_read  = (state_q == RD_INT) || (state_q == RD_STR) || (state_q == RD_CHR);
    assign pop      = in_read && !fifo_empty;
    assign stall    = (req && (state_q == IDLE)) || in_read;
    assign rd_valid = (state_q == DONE);
    assign rd       = rd_q;
    assign in_ready = !fifo_full;

    assign is_digit = (head >= ASCII_ZERO) && (head <= ASCII_NINE);
    assign is_space = (head == ASCII_SP) || (head == ASCII_NL);
    assign digit    = {24'h0, head - ASCII_ZERO};
    assign acc_next = acc_q * 32'd10 + digit;
    assign str_byte = {head, 24'h0} >> {cnt_q, 3'b000};

    // In RD_INT a non-zero cnt means a sign or digit has been seen, so
    // whitespace and '-' are no longer leading.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    acc_d = '0;
                    neg_d = 1'b0;
                    cnt_d = '0;
                    if (rs == SC_READ_INT)      state_d = RD_INT;
                    else if (rs == SC_READ_STR) state_d = RD_STR;
                    else                        state_d = RD_CHR;
                end
            end
            RD_INT: begin
                if (pop) begin
                    if (cnt_q == 2'd0 && is_space) begin
                        state_d = RD_INT;
                    end else if (cnt_q == 2'd0 && head == ASCII_MINUS) begin
                        neg_d = 1'b1;
                        cnt_d = 2'd1;
                    end else if (is_digit) begin
                        acc_d = acc_next;
                        cnt_d = 2'd1;
                    end else begin
                        rd_d    = neg_q ? (32'd0 - acc_q) : acc_q;
                        state_d = DONE;
                    end
                end
            end
            RD_STR: begin
                if (pop) begin
                    if (head == ASCII_NL) begin
                        rd_d    = acc_q;
                        state_d = DONE;
                    end else begin
                        acc_d = acc_q | str_byte;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            rd_d    = acc_q | str_byte;
                            state_d = DONE;
                        end
                    end
                end
            end
            RD_CHR: begin
                if (pop) begin
                    rd_d    = {24'h0, head};
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire
